// File: rtl/draw_sequencer.sv
// Frame-paced draw sequencer: a frame timer starts passes that hand the VGA write port to each
// unmasked channel in turn, with a per-channel draw timeout and sticky overrun/timeout flags.
module draw_sequencer #(
  parameter int unsigned N_CH         = 3,
  parameter int unsigned X_W          = 9,
  parameter int unsigned Y_W          = 8,
  parameter int unsigned C_W          = 6,
  parameter int unsigned FRAME_COUNT  = 1666666,
  parameter int unsigned CNT_W        = 24,
  parameter int unsigned DRAW_TIMEOUT = 131072
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [N_CH-1:0]       ch_mask,
  input  logic [N_CH-1:0]       ch_done,
  input  logic [N_CH*X_W-1:0]   ch_x,
  input  logic [N_CH*Y_W-1:0]   ch_y,
  input  logic [N_CH*C_W-1:0]   ch_colour,
  input  logic [N_CH-1:0]       ch_write,
  output logic [N_CH-1:0]       ch_draw_en,
  output logic [X_W-1:0]        x_position,
  output logic [Y_W-1:0]        y_position,
  output logic [C_W-1:0]        colour,
  output logic                  VGA_enable,
  output logic                  frame_tick,
  output logic                  busy,
  output logic                  overrun,
  output logic                  timeout
);

  localparam int unsigned IDX_W = $clog2(N_CH + 1);
  localparam int unsigned DC_W  = $clog2(DRAW_TIMEOUT + 1);

  localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(FRAME_COUNT - 1);
  localparam logic [DC_W-1:0]  DRAW_LAST  = DC_W'(DRAW_TIMEOUT - 1);
  localparam logic [IDX_W-1:0] IDX_END    = IDX_W'(N_CH);

  typedef enum logic [1:0] {StIdle, StSelect, StDraw} state_e;

  state_e           r_state;
  logic [IDX_W-1:0] r_idx;
  logic [CNT_W-1:0] r_frame_cnt;
  logic [DC_W-1:0]  r_draw_cnt;
  logic             r_pending;
  logic             r_overrun;
  logic             r_timeout;

  logic             w_tick;
  logic             w_busy;
  logic             w_start;
  logic             w_sel_mask;
  logic             w_sel_done;
  logic             w_sel_write;
  logic [X_W-1:0]   w_sel_x;
  logic [Y_W-1:0]   w_sel_y;
  logic [C_W-1:0]   w_sel_c;

  assign w_tick  = enable & (r_frame_cnt == FRAME_LAST);
  assign w_busy  = (r_state != StIdle);
  // A latched start only counts while the timer is still enabled.
  assign w_start = w_tick | (r_pending & enable);

  always_ff @(posedge clock) begin
    if (reset || !enable || (r_frame_cnt == FRAME_LAST)) begin
      r_frame_cnt <= '0;
    end else begin
      r_frame_cnt <= r_frame_cnt + 1'b1;
    end
  end

  // Decode the channel currently addressed by r_idx; an out-of-range index selects nothing.
  always_comb begin
    w_sel_mask  = 1'b0;
    w_sel_done  = 1'b0;
    w_sel_write = 1'b0;
    w_sel_x     = '0;
    w_sel_y     = '0;
    w_sel_c     = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (r_idx == IDX_W'(i)) begin
        w_sel_mask  = ch_mask[i];
        w_sel_done  = ch_done[i];
        w_sel_write = ch_write[i];
        w_sel_x     = ch_x[i*X_W +: X_W];
        w_sel_y     = ch_y[i*Y_W +: Y_W];
        w_sel_c     = ch_colour[i*C_W +: C_W];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= StIdle;
      r_idx      <= '0;
      r_draw_cnt <= '0;
      r_pending  <= 1'b0;
      r_overrun  <= 1'b0;
      r_timeout  <= 1'b0;
    end else begin
      if (w_tick && w_busy) begin
        r_overrun <= 1'b1;
      end

      if (!enable) begin
        r_pending <= 1'b0;
      end else if (w_tick && w_busy) begin
        r_pending <= 1'b1;
      end else if (!w_busy && w_start) begin
        r_pending <= 1'b0;
      end

      unique case (r_state)
        StIdle: begin
          if (w_start) begin
            r_state <= StSelect;
            r_idx   <= '0;
          end
        end
        StSelect: begin
          if (r_idx >= IDX_END) begin
            r_state <= StIdle;
          end else if (w_sel_mask) begin
            r_idx <= r_idx + 1'b1;
          end else begin
            r_state    <= StDraw;
            r_draw_cnt <= '0;
          end
        end
        StDraw: begin
          r_draw_cnt <= r_draw_cnt + 1'b1;
          if (w_sel_done) begin
            r_state <= StSelect;
            r_idx   <= r_idx + 1'b1;
          end else if (r_draw_cnt == DRAW_LAST) begin
            r_state   <= StSelect;
            r_idx     <= r_idx + 1'b1;
            r_timeout <= 1'b1;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  always_comb begin
    ch_draw_en = '0;
    x_position = '0;
    y_position = '0;
    colour     = '0;
    VGA_enable = 1'b0;
    if (r_state == StDraw) begin
      for (int i = 0; i < N_CH; i++) begin
        ch_draw_en[i] = (r_idx == IDX_W'(i));
      end
      x_position = w_sel_x;
      y_position = w_sel_y;
      colour     = w_sel_c;
      VGA_enable = w_sel_write & ~w_sel_done;
    end
  end

  assign frame_tick = w_tick;
  assign busy       = w_busy;
  assign overrun    = r_overrun;
  assign timeout    = r_timeout;

endmodule

// File: tb/tb_draw_sequencer.sv
// Bench for draw_sequencer: channel stubs finish after a configured delay; a pass-timeline model
// predicts every output each cycle.
module tb_draw_sequencer;

  localparam int unsigned N_CH  = 3;
  localparam int unsigned X_W   = 9;
  localparam int unsigned Y_W   = 8;
  localparam int unsigned C_W   = 6;
  localparam int unsigned FC    = 10;
  localparam int unsigned CNT_W = 4;
  localparam int unsigned DT    = 8;

  logic                clock = 1'b0;
  logic                reset = 1'b1;
  logic                enable = 1'b0;
  logic [N_CH-1:0]     ch_mask = '0;
  logic [N_CH-1:0]     ch_done = '0;
  logic [N_CH*X_W-1:0] ch_x = '0;
  logic [N_CH*Y_W-1:0] ch_y = '0;
  logic [N_CH*C_W-1:0] ch_colour = '0;
  logic [N_CH-1:0]     ch_write = '0;
  logic [N_CH-1:0]     ch_draw_en;
  logic [X_W-1:0]      x_position;
  logic [Y_W-1:0]      y_position;
  logic [C_W-1:0]      colour;
  logic                VGA_enable;
  logic                frame_tick;
  logic                busy;
  logic                overrun;
  logic                timeout;

  draw_sequencer #(
    .N_CH(N_CH), .X_W(X_W), .Y_W(Y_W), .C_W(C_W),
    .FRAME_COUNT(FC), .CNT_W(CNT_W), .DRAW_TIMEOUT(DT)
  ) dut (
    .clock(clock), .reset(reset), .enable(enable),
    .ch_mask(ch_mask), .ch_done(ch_done), .ch_x(ch_x), .ch_y(ch_y),
    .ch_colour(ch_colour), .ch_write(ch_write), .ch_draw_en(ch_draw_en),
    .x_position(x_position), .y_position(y_position), .colour(colour),
    .VGA_enable(VGA_enable), .frame_tick(frame_tick), .busy(busy),
    .overrun(overrun), .timeout(timeout)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad = 0;

  // Channel stubs: done rises dly cycles after draw enable; dly >= DT means never.
  int             dly [N_CH];
  int             cfg_dly [N_CH];
  logic [N_CH-1:0] cfg_mask;
  int             age [N_CH];
  logic [N_CH-1:0] prev_en = '0;
  logic [X_W-1:0] xa [N_CH];
  logic [Y_W-1:0] ya [N_CH];
  logic [C_W-1:0] ca [N_CH];
  logic           wr_a [N_CH];
  logic           done_a [N_CH];

  // Model: queue of per-cycle pass activity (-1 = selecting, k = drawing channel k).
  int q_code[$];
  bit q_to[$];
  int n_prev = 0;
  bit m_pend = 0;
  bit m_ovr = 0;
  bit m_to = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s at %0t: observed=%0h expected=%0h", tag, $time, got, want);
    end
  endtask

  task automatic build_pass();
    for (int i = 0; i < N_CH; i++) begin
      q_code.push_back(-1);
      q_to.push_back(1'b0);
      if (!ch_mask[i]) begin
        int len;
        len = (dly[i] < int'(DT)) ? dly[i] + 1 : int'(DT);
        for (int j = 0; j < len; j++) begin
          q_code.push_back(i);
          q_to.push_back((dly[i] >= int'(DT)) && (j == len - 1));
        end
      end
    end
    q_code.push_back(-1);
    q_to.push_back(1'b0);
  endtask

  task automatic drive_stubs();
    for (int i = 0; i < N_CH; i++) begin
      if (ch_draw_en[i]) age[i] = prev_en[i] ? age[i] + 1 : 0;
      else age[i] = 0;
      done_a[i] = ch_draw_en[i] ? (age[i] >= dly[i]) : ($urandom_range(0, 3) == 0);
      wr_a[i] = 1'($urandom_range(0, 1));
      xa[i] = X_W'($urandom);
      ya[i] = Y_W'($urandom);
      ca[i] = C_W'($urandom);
      ch_done[i] = done_a[i];
      ch_write[i] = wr_a[i];
      ch_x[i*X_W +: X_W] = xa[i];
      ch_y[i*Y_W +: Y_W] = ya[i];
      ch_colour[i*C_W +: C_W] = ca[i];
    end
    prev_en = ch_draw_en;
  endtask

  task automatic check_and_advance();
    int c;
    int n;
    bit tick_e;
    bit was_busy;
    bit start;
    int dummy;
    c = (q_code.size() > 0) ? q_code[0] : -1;
    n = enable ? n_prev + 1 : 0;
    tick_e = enable && (n % int'(FC) == 0);
    chk("draw_en", 32'(ch_draw_en), (c >= 0) ? (32'd1 << c) : 32'd0);
    chk("busy", 32'(busy), 32'(q_code.size() > 0));
    chk("frame_tick", 32'(frame_tick), 32'(tick_e));
    chk("overrun", 32'(overrun), 32'(m_ovr));
    chk("timeout", 32'(timeout), 32'(m_to));
    chk("x_position", 32'(x_position), (c >= 0) ? 32'(xa[c]) : 32'd0);
    chk("y_position", 32'(y_position), (c >= 0) ? 32'(ya[c]) : 32'd0);
    chk("colour", 32'(colour), (c >= 0) ? 32'(ca[c]) : 32'd0);
    chk("VGA_enable", 32'(VGA_enable), (c >= 0) ? 32'(wr_a[c] & ~done_a[c]) : 32'd0);
    if (reset) begin
      q_code.delete();
      q_to.delete();
      n_prev = 0;
      m_pend = 0;
      m_ovr = 0;
      m_to = 0;
    end else begin
      was_busy = (q_code.size() > 0);
      start = !was_busy && (tick_e || (m_pend && enable));
      if (was_busy) begin
        dummy = q_code.pop_front();
        if (q_to.pop_front()) m_to = 1;
      end
      if (tick_e && was_busy) begin
        m_ovr = 1;
        m_pend = 1;
      end
      if (!enable || start) m_pend = 0;
      if (start) build_pass();
      n_prev = enable ? n % int'(FC) : 0;
    end
  endtask

  task automatic cycle(input bit en, input bit rst, input bit cfg);
    @(posedge clock);
    #1;
    enable = en;
    reset = rst;
    if (cfg) begin
      ch_mask = cfg_mask;
      for (int i = 0; i < N_CH; i++) dly[i] = cfg_dly[i];
    end
    drive_stubs();
    @(negedge clock);
    check_and_advance();
  endtask

  task automatic phase(input logic [N_CH-1:0] m, input int d0, input int d1, input int d2,
                       input int cycles);
    cfg_mask = m;
    cfg_dly[0] = d0;
    cfg_dly[1] = d1;
    cfg_dly[2] = d2;
    cycle(1'b1, 1'b1, 1'b1);
    repeat (cycles) cycle(1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    bit found;
    for (int i = 0; i < N_CH; i++) begin
      dly[i] = 5;
      age[i] = 0;
      xa[i] = '0;
      ya[i] = '0;
      ca[i] = '0;
      wr_a[i] = 1'b0;
      done_a[i] = 1'b0;
    end
    cycle(1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b1, 1'b0);
    chk("reset_busy", 32'(busy), 32'd0);

    // Timer only, all channels masked: ticks every FC cycles, N_CH+1 select cycles per pass.
    phase(3'b111, 5, 5, 5, 35);
    // Full sequence, one channel skipped, timeout on channel 0, 25-cycle passes with overrun.
    phase(3'b000, 5, 5, 5, 60);
    phase(3'b010, 5, 5, 5, 60);
    phase(3'b000, 100, 3, 2, 60);
    phase(3'b000, 6, 6, 6, 90);
    chk("overrun_set", 32'(overrun), 32'd1);

    // Reset during the draw of channel 1.
    phase(3'b000, 5, 5, 5, 0);
    found = 0;
    for (int k = 0; k < 60 && !found; k++) begin
      cycle(1'b1, 1'b0, 1'b0);
      if (ch_draw_en == 3'b010) found = 1;
    end
    chk("reach_ch1_draw", 32'(found), 32'd1);
    cycle(1'b1, 1'b1, 1'b0);
    cycle(1'b1, 1'b0, 1'b0);
    chk("midpass_rst_draw_en", 32'(ch_draw_en), 32'd0);
    chk("midpass_rst_busy", 32'(busy), 32'd0);

    // Enable dropped mid-pass with a start pending: pass completes, no further pass.
    phase(3'b000, 6, 6, 6, 22);
    repeat (40) cycle(1'b0, 1'b0, 1'b0);
    chk("disable_idle", 32'(busy), 32'd0);

    for (int p = 0; p < 8; p++) begin
      bit en_r;
      bit rst_r;
      cfg_mask = N_CH'($urandom_range(0, 7));
      for (int i = 0; i < N_CH; i++) cfg_dly[i] = $urandom_range(0, 10);
      cycle(1'b1, 1'b1, 1'b1);
      en_r = 1'b1;
      for (int k = 0; k < 150; k++) begin
        if ($urandom_range(0, 24) == 0) en_r = !en_r;
        rst_r = ($urandom_range(0, 199) == 0);
        cycle(en_r, rst_r, 1'b0);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
